mat_addsub_stream: RTL and testbench
====================================

# mat_addsub_stream

Row-streamed, parametrised signed matrix add/subtract engine: M×N matrices of DATA_LEN-bit two's-complement elements, one row of A and one row of B per accepted beat, one result row of C = A ± B per output beat. Successor to the flat combinational 8×8 adder: arbitrary M/N, add/sub mode, valid/ready flow control, row tagging and overflow reporting. Sits between the matrix operand buffers and the result writer in the matrix datapath.

## Interface
- DATA_LEN, 32, element width in bits (≥2)
- M, 8, rows per matrix (≥1)
- N, 8, elements per row (≥1)
- ROW_SIZE, DATA_LEN*N, row bus width (derived, do not override)
- IDX_W, (M>1 ? $clog2(M) : 1), row index width (derived)

- i_clk  in  1  clock, rising edge
- i_rstn  in  1  asynchronous active-low reset
- i_mode  in  1  0 = add (A+B), 1 = subtract (A−B); sampled on the row-0 beat only
- i_valid  in  1  input row valid
- o_ready  out  1  input row accepted when i_valid && o_ready
- i_row_a  in  ROW_SIZE  row of A; element j at [DATA_LEN*j +: DATA_LEN]
- i_row_b  in  ROW_SIZE  row of B, same packing
- o_valid  out  1  result row valid
- i_ready  in  1  downstream accepts when o_valid && i_ready
- o_row_c  out  ROW_SIZE  result row, same packing
- o_row_idx  out  IDX_W  row number (0..M−1) of o_row_c
- o_last  out  1  high with row M−1
- o_ovf  out  N  per-element signed overflow flag for this row
- o_busy  out  1  high while a matrix is partially accepted (state RUN)

## Operation
- FSM states: IDLE (next accepted beat is row 0), RUN (rows 1..M−1 expected).
- IDLE → RUN on accepted beat when M>1; i_mode latched into mode register on that beat. M=1: stays IDLE, every beat is row 0 and last.
- RUN → IDLE on accepted beat with row counter = M−1; counter returns to 0. Otherwise counter +1 per accepted beat.
- i_mode ignored in RUN; whole matrix uses latched mode (row-0 beat uses i_mode directly).
- Per element: sum/diff computed in DATA_LEN+1 bits; overflow when result outside [−2^(DATA_LEN−1), 2^(DATA_LEN−1)−1]. Add: operands same sign, result sign differs. Sub: operand signs differ, result sign differs from A.
- Default result: low DATA_LEN bits (wrap); o_ovf[j] reports overflow regardless.
- No gaps between matrices required; row 0 of the next matrix may follow row M−1 back-to-back.

## Timing
- Reset (async assert, sync release): state IDLE, counter 0, o_valid 0, o_row_c 0, o_row_idx 0, o_last 0, o_ovf 0, o_busy 0; o_ready = 1 while i_rstn high.
- Latency: 1 cycle, accepted beat at edge k → result registered, o_valid high after edge k.
- o_ready = !o_valid || i_ready (combinational); full throughput 1 row/cycle under continuous i_ready.
- Backpressure: while o_valid && !i_ready, all outputs hold stable, o_ready 0, counter and state frozen.
- Simultaneous output drain and input accept in one cycle: new row replaces old, o_valid stays 1.
- i_valid without o_ready: no state change; inputs must be held by source.
- Reset mid-matrix: partial matrix and pending output discarded; next accepted beat is row 0.

## Configuration
- MAT_ADDSUB_SAT_EN defined: overflowed elements clamp to 2^(DATA_LEN−1)−1 (positive overflow) or −2^(DATA_LEN−1) (negative); o_ovf unchanged.
- Undefined: two's-complement wrap as in Operation.

## Structure
- Package mat_pkg: mode enum (MODE_ADD=0, MODE_SUB=1), FSM state enum (S_IDLE, S_RUN), saturation limit constants as functions of DATA_LEN.
- Sub-module mat_addsub_lane: one element, combinational add/sub, overflow detect, optional saturation; instantiated N times by generate loop. Top holds FSM, counter, mode register, output register.

## Test plan
- Defaults, add, A[r][j]=r*8+j, B=100, i_ready=1 → 8 beats, C=r*8+j+100, o_row_idx 0..7, o_last only on idx 7, o_ovf=0.
- Sub, row 0: A=5, B=7 → C=−2 (0xFFFFFFFE); i_mode toggled to add on rows 1..7 → all rows still subtract.
- A=0x7FFFFFFF, B=1 add → wrap 0x80000000, o_ovf[j]=1; with MAT_ADDSUB_SAT_EN → 0x7FFFFFFF, o_ovf[j]=1; sub 0x80000000−1 → saturates 0x80000000.
- i_ready low 3 cycles with o_valid high → outputs stable, o_ready 0, no row lost or duplicated; random i_valid/i_ready over 20 matrices → scoreboard match.
- i_rstn pulsed low after row 3 accepted → o_valid 0, o_busy 0 immediately; next matrix starts at o_row_idx 0.
- M=1, N=3, DATA_LEN=8: each beat → o_last=1, o_row_idx=0, o_busy stays 0; 127+1 → o_ovf=1.

Source files
------------

// File: rtl/mat_pkg.sv
// mat_pkg: shared types and helpers for the row-streamed matrix add/subtract engine.
//   mode_e  : element operation (MODE_ADD = A+B, MODE_SUB = A-B)
//   state_e : matrix sequencing state (S_IDLE = expecting row 0, S_RUN = rows 1..M-1)
//   sat_max / sat_min : signed saturation limits for a given element width,
//                       returned zero-extended in LIMIT_W bits (slice the low bits).
package mat_pkg;

  typedef enum logic {
    MODE_ADD = 1'b0,
    MODE_SUB = 1'b1
  } mode_e;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_e;

  localparam int unsigned LIMIT_W = 128;

  // 0111...1 in the low dl bits
  function automatic logic [LIMIT_W-1:0] sat_max(input int unsigned dl);
    sat_max = (LIMIT_W'(1) << (dl - 1)) - LIMIT_W'(1);
  endfunction

  // 1000...0 in the low dl bits
  function automatic logic [LIMIT_W-1:0] sat_min(input int unsigned dl);
    sat_min = LIMIT_W'(1) << (dl - 1);
  endfunction

endpackage

// File: rtl/mat_addsub_lane.sv
// mat_addsub_lane: one element of the matrix add/subtract datapath (combinational).
//   a, b : DATA_LEN-bit two's-complement operands
//   mode : MODE_ADD -> a+b, MODE_SUB -> a-b
//   c    : DATA_LEN-bit result (wrapped, or clamped when MAT_ADDSUB_SAT_EN is defined)
//   ovf  : signed overflow of the exact result
// Optional feature macro: MAT_ADDSUB_SAT_EN (saturate overflowed results).
module mat_addsub_lane
  import mat_pkg::*;
#(
  parameter int unsigned DATA_LEN = 32
) (
  input  logic [DATA_LEN-1:0] a,
  input  logic [DATA_LEN-1:0] b,
  input  mode_e               mode,
  output logic [DATA_LEN-1:0] c,
  output logic                ovf
);

`ifdef MAT_ADDSUB_SAT_EN
  localparam logic [LIMIT_W-1:0]  MAX_FULL = sat_max(DATA_LEN);
  localparam logic [LIMIT_W-1:0]  MIN_FULL = sat_min(DATA_LEN);
  localparam logic [DATA_LEN-1:0] SAT_MAX  = MAX_FULL[DATA_LEN-1:0];
  localparam logic [DATA_LEN-1:0] SAT_MIN  = MIN_FULL[DATA_LEN-1:0];
`endif

  logic [DATA_LEN:0] a_x;
  logic [DATA_LEN:0] b_x;
  logic [DATA_LEN:0] r;

  always_comb begin
    a_x = {a[DATA_LEN-1], a};
    b_x = {b[DATA_LEN-1], b};
    r   = (mode == MODE_SUB) ? (a_x - b_x) : (a_x + b_x);
    // The exact result fits in DATA_LEN+1 bits; it is out of range exactly
    // when its top two bits disagree.
    ovf = r[DATA_LEN] ^ r[DATA_LEN-1];
`ifdef MAT_ADDSUB_SAT_EN
    if (ovf) begin
      // r[DATA_LEN] is the true sign of the exact result
      c = r[DATA_LEN] ? SAT_MIN : SAT_MAX;
    end else begin
      c = r[DATA_LEN-1:0];
    end
`else
    c = r[DATA_LEN-1:0];
`endif
  end

endmodule

// File: rtl/mat_addsub_stream.sv
// mat_addsub_stream: row-streamed signed matrix add/subtract, C = A +/- B.
// One row of A and B accepted per beat (i_valid && o_ready), one registered
// result row per output beat (o_valid && i_ready), 1-cycle latency.
//   i_clk, i_rstn         : clock, asynchronous active-low reset
//   i_mode                : 0 add / 1 subtract, sampled on the row-0 beat only
//   i_valid, o_ready      : input row handshake
//   i_row_a, i_row_b      : operand rows, element j at [DATA_LEN*j +: DATA_LEN]
//   o_valid, i_ready      : output row handshake
//   o_row_c               : result row, same packing
//   o_row_idx, o_last     : row number of o_row_c, high with row M-1
//   o_ovf                 : per-element signed overflow
//   o_busy                : matrix partially accepted
// Optional feature macro: MAT_ADDSUB_SAT_EN (saturate instead of wrap, in the lanes).
module mat_addsub_stream
  import mat_pkg::*;
#(
  parameter  int unsigned DATA_LEN = 32,
  parameter  int unsigned M        = 8,
  parameter  int unsigned N        = 8,
  localparam int unsigned ROW_SIZE = DATA_LEN * N,
  localparam int unsigned IDX_W    = (M > 1) ? $clog2(M) : 1
) (
  input  logic                i_clk,
  input  logic                i_rstn,
  input  logic                i_mode,
  input  logic                i_valid,
  output logic                o_ready,
  input  logic [ROW_SIZE-1:0] i_row_a,
  input  logic [ROW_SIZE-1:0] i_row_b,
  output logic                o_valid,
  input  logic                i_ready,
  output logic [ROW_SIZE-1:0] o_row_c,
  output logic [IDX_W-1:0]    o_row_idx,
  output logic                o_last,
  output logic [N-1:0]        o_ovf,
  output logic                o_busy
);

  state_e             state_q;
  state_e             state_d;
  logic [IDX_W-1:0]   cnt_q;
  mode_e              mode_q;
  mode_e              row_mode;
  logic               accept;
  logic               row_last;
  logic [ROW_SIZE-1:0] c_d;
  logic [N-1:0]       ovf_d;

  assign o_ready  = !o_valid || i_ready;
  assign accept   = i_valid && o_ready;
  // cnt_q is 0 in S_IDLE, so with M=1 every beat is both row 0 and last
  assign row_last = (cnt_q == IDX_W'(M - 1));
  // Row 0 uses i_mode directly; later rows use the mode latched on row 0
  assign row_mode = (state_q == S_IDLE) ? mode_e'(i_mode) : mode_q;

  // State register
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: an accepted last row returns to IDLE, any other accepted row
  // leaves the FSM in RUN (covers IDLE->RUN and RUN->RUN alike).
  always_comb begin
    state_d = state_q;
    if (accept) begin
      state_d = row_last ? S_IDLE : S_RUN;
    end
  end

  // State-decoded outputs
  always_comb begin
    o_busy = (state_q == S_RUN);
  end

  // Row counter and mode register
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      cnt_q  <= '0;
      mode_q <= MODE_ADD;
    end else if (accept) begin
      cnt_q <= row_last ? '0 : cnt_q + IDX_W'(1);
      if (state_q == S_IDLE) begin
        mode_q <= mode_e'(i_mode);
      end
    end
  end

  // Element lanes
  for (genvar j = 0; j < N; j++) begin : g_lane
    mat_addsub_lane #(
      .DATA_LEN(DATA_LEN)
    ) u_lane (
      .a   (i_row_a[DATA_LEN*j +: DATA_LEN]),
      .b   (i_row_b[DATA_LEN*j +: DATA_LEN]),
      .mode(row_mode),
      .c   (c_d[DATA_LEN*j +: DATA_LEN]),
      .ovf (ovf_d[j])
    );
  end

  // Output register: an accept overwrites (covers simultaneous drain+accept),
  // a drain without accept clears o_valid, otherwise everything holds.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      o_valid   <= 1'b0;
      o_row_c   <= '0;
      o_row_idx <= '0;
      o_last    <= 1'b0;
      o_ovf     <= '0;
    end else if (accept) begin
      o_valid   <= 1'b1;
      o_row_c   <= c_d;
      o_row_idx <= cnt_q;
      o_last    <= row_last;
      o_ovf     <= ovf_d;
    end else if (i_ready) begin
      o_valid   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mat_addsub_stream.sv
// tb_mat_addsub_stream: self-checking bench for mat_addsub_stream.
// u0: default 8x8 of 32-bit elements, scoreboard-checked; u1: M=1, N=3, 8-bit.
// Honours MAT_ADDSUB_SAT_EN in its reference model and directed constants.
module tb_mat_addsub_stream;

  localparam int DL  = 32;
  localparam int M0  = 8;
  localparam int N0  = 8;
  localparam int RS0 = DL * N0;
  localparam int DL1 = 8;
  localparam int N1  = 3;
  localparam int RS1 = DL1 * N1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rstn;
  logic           mode, valid, o_ready, o_valid, i_ready, last, busy;
  logic [RS0-1:0] row_a, row_b, row_c;
  logic [2:0]     idx;
  logic [N0-1:0]  ovf;

  logic           mode1, valid1, o_ready1, o_valid1, i_ready1, last1, busy1;
  logic [RS1-1:0] a1, b1, c1;
  logic [0:0]     idx1;
  logic [N1-1:0]  ovf1;

  mat_addsub_stream #(.DATA_LEN(DL), .M(M0), .N(N0)) u0 (
    .i_clk(clk), .i_rstn(rstn), .i_mode(mode), .i_valid(valid), .o_ready(o_ready),
    .i_row_a(row_a), .i_row_b(row_b), .o_valid(o_valid), .i_ready(i_ready),
    .o_row_c(row_c), .o_row_idx(idx), .o_last(last), .o_ovf(ovf), .o_busy(busy)
  );

  mat_addsub_stream #(.DATA_LEN(DL1), .M(1), .N(N1)) u1 (
    .i_clk(clk), .i_rstn(rstn), .i_mode(mode1), .i_valid(valid1), .o_ready(o_ready1),
    .i_row_a(a1), .i_row_b(b1), .o_valid(o_valid1), .i_ready(i_ready1),
    .o_row_c(c1), .o_row_idx(idx1), .o_last(last1), .o_ovf(ovf1), .o_busy(busy1)
  );

  typedef struct {
    logic [RS0-1:0] c;
    logic [2:0]     idx;
    logic           last;
    logic [N0-1:0]  ovf;
  } exp_t;

  exp_t q0[$];
  int   ncomp = 0;
  int   nfail = 0;
  int   m_cnt = 0;
  logic m_mode = 1'b0;
  bit   rnd_rdy = 1'b0;
  bit   last_acc = 1'b0;

  task automatic chk(input string tag, input logic [RS0-1:0] obs, input logic [RS0-1:0] exp);
    ncomp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic longint sext(input logic [63:0] v, input int dl);
    longint x;
    x = longint'(v & ((64'd1 << dl) - 64'd1));
    if (x >= (longint'(1) <<< (dl - 1))) x = x - (longint'(1) <<< dl);
    return x;
  endfunction

  // Reference element: exact arithmetic, range check against the signed limits
  function automatic void elem(input longint a, input longint b, input bit sub, input int dl,
                               output logic [63:0] c, output bit ov);
    longint hi, lo, r;
    hi = (longint'(1) <<< (dl - 1)) - 1;
    lo = -(longint'(1) <<< (dl - 1));
    r  = sub ? (a - b) : (a + b);
    ov = (r > hi) || (r < lo);
`ifdef MAT_ADDSUB_SAT_EN
    if (r > hi) r = hi;
    else if (r < lo) r = lo;
`endif
    c = 64'(r);
  endfunction

  function automatic void model_row0(input logic [RS0-1:0] a, input logic [RS0-1:0] b, input bit sub,
                                     output logic [RS0-1:0] c, output logic [N0-1:0] o);
    c = '0;
    o = '0;
    for (int j = 0; j < N0; j++) begin
      logic [63:0] e;
      bit          v;
      elem(sext(64'(a[DL*j +: DL]), DL), sext(64'(b[DL*j +: DL]), DL), sub, DL, e, v);
      c[DL*j +: DL] = e[DL-1:0];
      o[j] = v;
    end
  endfunction

  function automatic void model_row1(input logic [RS1-1:0] a, input logic [RS1-1:0] b, input bit sub,
                                     output logic [RS1-1:0] c, output logic [N1-1:0] o);
    c = '0;
    o = '0;
    for (int j = 0; j < N1; j++) begin
      logic [63:0] e;
      bit          v;
      elem(sext(64'(a[DL1*j +: DL1]), DL1), sext(64'(b[DL1*j +: DL1]), DL1), sub, DL1, e, v);
      c[DL1*j +: DL1] = e[DL1-1:0];
      o[j] = v;
    end
  endfunction

  function automatic logic [RS0-1:0] fill(input logic [DL-1:0] v);
    logic [RS0-1:0] r;
    for (int j = 0; j < N0; j++) r[DL*j +: DL] = v;
    return r;
  endfunction

  function automatic logic [RS0-1:0] rnd_row();
    logic [RS0-1:0] r;
    for (int j = 0; j < N0; j++) r[DL*j +: DL] = $urandom;
    return r;
  endfunction

  // Scoreboard step at the negative edge: compare a draining output, then
  // record the beat (if any) that the coming rising edge will accept.
  task automatic sample();
    exp_t e;
    logic [RS0-1:0] c;
    logic [N0-1:0]  o;
    bit sub;
    if (o_valid && i_ready) begin
      chk("sb_nonempty", RS0'(q0.size() != 0), RS0'(1));
      if (q0.size() != 0) begin
        e = q0.pop_front();
        chk("sb_row_c", row_c, e.c);
        chk("sb_row_idx", RS0'(idx), RS0'(e.idx));
        chk("sb_last", RS0'(last), RS0'(e.last));
        chk("sb_ovf", RS0'(ovf), RS0'(e.ovf));
      end
    end
    last_acc = valid && o_ready;
    if (last_acc) begin
      if (m_cnt == 0) m_mode = mode;
      sub = (m_cnt == 0) ? mode : m_mode;
      model_row0(row_a, row_b, sub, c, o);
      e.c = c;
      e.idx = 3'(m_cnt);
      e.last = (m_cnt == M0 - 1);
      e.ovf = o;
      q0.push_back(e);
      m_cnt = (m_cnt == M0 - 1) ? 0 : m_cnt + 1;
    end
  endtask

  task automatic tick();
    @(negedge clk);
    sample();
    @(posedge clk);
    #1;
    if (rnd_rdy) i_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic send0(input logic [RS0-1:0] a, input logic [RS0-1:0] b, input logic md);
    int g;
    valid = 1'b1;
    row_a = a;
    row_b = b;
    mode  = md;
    g = 0;
    do begin
      tick();
      g++;
    end while (!last_acc && g < 500);
    chk("send0_accepted", RS0'(last_acc), RS0'(1));
    valid = 1'b0;
  endtask

  task automatic drain();
    int g;
    g = 0;
    while ((q0.size() != 0 || o_valid) && g < 1000) begin
      tick();
      g++;
    end
    chk("drain_empty", RS0'(q0.size()), RS0'(0));
  endtask

  task automatic send1(input logic [RS1-1:0] a, input logic [RS1-1:0] b, input logic md);
    int g;
    bit acc;
    logic [RS1-1:0] ec;
    logic [N1-1:0]  eo;
    valid1 = 1'b1;
    a1 = a;
    b1 = b;
    mode1 = md;
    g = 0;
    do begin
      @(negedge clk);
      acc = valid1 && o_ready1;
      @(posedge clk);
      #1;
      g++;
    end while (!acc && g < 100);
    valid1 = 1'b0;
    chk("send1_accepted", RS0'(acc), RS0'(1));
    model_row1(a, b, md, ec, eo);
    chk("u1_row_c", RS0'(c1), RS0'(ec));
    chk("u1_ovf", RS0'(ovf1), RS0'(eo));
    chk("u1_last", RS0'(last1), RS0'(1));
    chk("u1_idx", RS0'(idx1), RS0'(0));
    chk("u1_busy", RS0'(busy1), RS0'(0));
  endtask

  initial begin
    logic [RS0-1:0] a, snap_c;
    logic [2:0]     snap_idx;
    logic [N0-1:0]  snap_ovf;
    logic           md;

    rstn = 1'b0; valid = 1'b0; mode = 1'b0; row_a = '0; row_b = '0; i_ready = 1'b1;
    valid1 = 1'b0; mode1 = 1'b0; a1 = '0; b1 = '0; i_ready1 = 1'b1;
    #2;
    chk("rst_valid", RS0'(o_valid), RS0'(0));
    chk("rst_row_c", row_c, RS0'(0));
    chk("rst_idx", RS0'(idx), RS0'(0));
    chk("rst_last", RS0'(last), RS0'(0));
    chk("rst_ovf", RS0'(ovf), RS0'(0));
    chk("rst_busy", RS0'(busy), RS0'(0));
    chk("rst_u1_valid", RS0'(o_valid1), RS0'(0));
    @(negedge clk);
    #1 rstn = 1'b1;
    #1 chk("rst_ready", RS0'(o_ready), RS0'(1));
    @(posedge clk);
    #1;

    // Add matrix: A[r][j] = r*8+j, B = 100
    for (int r = 0; r < M0; r++) begin
      for (int j = 0; j < N0; j++) a[DL*j +: DL] = DL'(r * 8 + j);
      send0(a, fill(32'd100), 1'b0);
      if (r == 0) begin
        chk("add_r0_e0", RS0'(row_c[DL-1:0]), RS0'(100));
        chk("add_busy_run", RS0'(busy), RS0'(1));
      end
    end
    chk("add_r7_e7", RS0'(row_c[DL*7 +: DL]), RS0'(7 * 8 + 7 + 100));
    chk("add_r7_last", RS0'(last), RS0'(1));
    chk("add_r7_idx", RS0'(idx), RS0'(7));
    chk("add_busy_idle", RS0'(busy), RS0'(0));

    // Subtract latched on row 0; i_mode says add on later rows
    send0(fill(32'd5), fill(32'd7), 1'b1);
    chk("sub_r0", RS0'(row_c[DL-1:0]), RS0'(32'hFFFF_FFFE));
    for (int r = 1; r < M0; r++) send0(fill(32'd5), fill(32'd7), 1'b0);
    chk("sub_r7_latched", RS0'(row_c[DL-1:0]), RS0'(32'hFFFF_FFFE));

    // Positive overflow on add
    send0(fill(32'h7FFF_FFFF), fill(32'd1), 1'b0);
`ifdef MAT_ADDSUB_SAT_EN
    chk("ovf_add_val", RS0'(row_c[DL-1:0]), RS0'(32'h7FFF_FFFF));
`else
    chk("ovf_add_val", RS0'(row_c[DL-1:0]), RS0'(32'h8000_0000));
`endif
    chk("ovf_add_flag", RS0'(ovf), RS0'(8'hFF));
    for (int r = 1; r < M0; r++) send0(rnd_row(), rnd_row(), 1'b0);

    // Negative overflow on subtract
    send0(fill(32'h8000_0000), fill(32'd1), 1'b1);
`ifdef MAT_ADDSUB_SAT_EN
    chk("ovf_sub_val", RS0'(row_c[DL-1:0]), RS0'(32'h8000_0000));
`else
    chk("ovf_sub_val", RS0'(row_c[DL-1:0]), RS0'(32'h7FFF_FFFF));
`endif
    chk("ovf_sub_flag", RS0'(ovf), RS0'(8'hFF));
    for (int r = 1; r < M0; r++) send0(rnd_row(), rnd_row(), 1'b1);

    // Backpressure: hold i_ready low for 3 cycles with a row waiting
    i_ready = 1'b0;
    snap_c = row_c;
    snap_idx = idx;
    snap_ovf = ovf;
    valid = 1'b1;
    row_a = rnd_row();
    row_b = rnd_row();
    mode = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("bp_valid", RS0'(o_valid), RS0'(1));
      chk("bp_ready", RS0'(o_ready), RS0'(0));
      chk("bp_row_c", row_c, snap_c);
      chk("bp_idx", RS0'(idx), RS0'(snap_idx));
      chk("bp_ovf", RS0'(ovf), RS0'(snap_ovf));
      chk("bp_no_accept", RS0'(last_acc), RS0'(0));
    end
    i_ready = 1'b1;
    send0(row_a, row_b, 1'b0);
    for (int r = 1; r < M0; r++) send0(rnd_row(), rnd_row(), 1'b1);

    // Random valid gaps and random i_ready over 20 matrices
    rnd_rdy = 1'b1;
    for (int m = 0; m < 20; m++) begin
      md = 1'($urandom_range(0, 1));
      for (int r = 0; r < M0; r++) begin
        repeat ($urandom_range(0, 2)) tick();
        send0(rnd_row(), rnd_row(), (r == 0) ? md : ~md);
      end
    end
    rnd_rdy = 1'b0;
    i_ready = 1'b1;
    drain();

    // Reset after row 3 accepted
    for (int r = 0; r < 4; r++) send0(rnd_row(), rnd_row(), 1'b1);
    rstn = 1'b0;
    valid = 1'b0;
    #1;
    chk("midrst_valid", RS0'(o_valid), RS0'(0));
    chk("midrst_busy", RS0'(busy), RS0'(0));
    chk("midrst_row_c", row_c, RS0'(0));
    chk("midrst_last", RS0'(last), RS0'(0));
    q0.delete();
    m_cnt = 0;
    @(negedge clk);
    #1 rstn = 1'b1;
    @(posedge clk);
    #1;
    send0(fill(32'd1), fill(32'd2), 1'b0);
    chk("midrst_idx0", RS0'(idx), RS0'(0));
    chk("midrst_r0_val", RS0'(row_c[DL-1:0]), RS0'(3));
    for (int r = 1; r < M0; r++) send0(rnd_row(), rnd_row(), 1'b0);
    drain();

    // M=1, N=3, 8-bit instance
    send1({8'd3, 8'd2, 8'd1}, {8'd6, 8'd5, 8'd4}, 1'b0);
    chk("u1_add_val", RS0'(c1), RS0'({8'd9, 8'd7, 8'd5}));
    send1({8'd10, 8'd1, 8'd127}, {8'd20, 8'd1, 8'd1}, 1'b0);
    chk("u1_127p1_flag", RS0'(ovf1), RS0'(3'b001));
`ifdef MAT_ADDSUB_SAT_EN
    chk("u1_127p1_val", RS0'(c1[7:0]), RS0'(8'h7F));
`else
    chk("u1_127p1_val", RS0'(c1[7:0]), RS0'(8'h80));
`endif
    send1({8'h80, 8'h80, 8'h05}, {8'h01, 8'hFF, 8'h07}, 1'b1);
    for (int k = 0; k < 4; k++) begin
      send1(RS1'($urandom), RS1'($urandom), 1'($urandom_range(0, 1)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncomp, nfail);
    $finish;
  end

endmodule
